// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: op encodings and default address width for the program counter
package pc_unit_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_INC  = 2'b01,
    OP_JMP  = 2'b10,
    OP_REL  = 2'b11
  } op_e;
endpackage

// File: rtl/pc_reg_bit.sv
// pc_reg_bit: one state bit with synchronous reset value and load enable
module pc_reg_bit (
  input  logic Clk,
  input  logic Rst,
  input  logic rst_val,
  input  logic en,
  input  logic d,
  output logic q
);
  always_ff @(posedge Clk)
    q <= Rst ? rst_val : en ? d : q;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with hold/inc/jump/relative branch; PC_CALL_RET_EN adds one-deep call/return
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Target,
  input  logic [WIDTH-1:0] Offset,
`ifdef PC_CALL_RET_EN
  input  logic             Call,
  input  logic             Ret,
  output logic [WIDTH-1:0] RetAddr,
`endif
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCInc,
  output logic             Wrap
);
  op_e              op;
  logic [WIDTH:0]   inc_sum, rel_sum;
  logic [WIDTH-1:0] pc_nxt;
  logic             wrap_nxt;
  assign op      = op_e'(Op);
  assign inc_sum = {1'b0, PC} + (WIDTH+1)'(1);
  assign rel_sum = {1'b0, PC} + {1'b0, Offset};
  assign PCInc   = inc_sum[WIDTH-1:0];
  // a relative branch wraps when the carry disagrees with the offset's sign
  always_comb begin
    pc_nxt   = op == OP_INC ? PCInc : op == OP_JMP ? Target : op == OP_REL ? rel_sum[WIDTH-1:0] : PC;
    wrap_nxt = En & ((op == OP_INC & inc_sum[WIDTH]) | (op == OP_REL & (rel_sum[WIDTH] ^ Offset[WIDTH-1])));
`ifdef PC_CALL_RET_EN
    pc_nxt   = Call ? Target : Ret ? RetAddr : pc_nxt;
    wrap_nxt = wrap_nxt & ~Call & ~Ret;
`endif
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_pc
    pc_reg_bit u_pc (.Clk, .Rst, .rst_val(RESET_VEC[i]), .en(En), .d(pc_nxt[i]), .q(PC[i]));
`ifdef PC_CALL_RET_EN
    pc_reg_bit u_ra (.Clk, .Rst, .rst_val(RESET_VEC[i]), .en(En & Call), .d(PCInc[i]), .q(RetAddr[i]));
`endif
  end
  pc_reg_bit u_wrap (.Clk, .Rst, .rst_val(1'b0), .en(1'b1), .d(wrap_nxt), .q(Wrap));
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors against an integer-arithmetic model of the program counter
module tb_pc_unit;
  logic       Clk = 0;
  logic       Rst = 1, En = 0, Call = 0, Ret = 0;
  logic [1:0] Op = 0;
  logic [7:0] Target = 0, Offset = 0;
  logic [7:0] pc_a, inc_a, pc_b, inc_b;
  logic       wrap_a, wrap_b;
`ifdef PC_CALL_RET_EN
  logic [7:0] ra_a, ra_b;
`endif
  int vecs = 0, errs = 0;
  int m_pc[2], m_ra[2];
  bit m_w[2];
  bit valid = 0;
  int rv[2] = '{0, 128};

  always #5 Clk = ~Clk;

  pc_unit #(.WIDTH(8), .RESET_VEC(8'h00)) dut_a (
    .Clk(Clk), .Rst(Rst), .En(En), .Op(Op), .Target(Target), .Offset(Offset),
`ifdef PC_CALL_RET_EN
    .Call(Call), .Ret(Ret), .RetAddr(ra_a),
`endif
    .PC(pc_a), .PCInc(inc_a), .Wrap(wrap_a));

  pc_unit #(.WIDTH(8), .RESET_VEC(8'h80)) dut_b (
    .Clk(Clk), .Rst(Rst), .En(En), .Op(Op), .Target(Target), .Offset(Offset),
`ifdef PC_CALL_RET_EN
    .Call(Call), .Ret(Ret), .RetAddr(ra_b),
`endif
    .PC(pc_b), .PCInc(inc_b), .Wrap(wrap_b));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // model: true signed sums checked against the address range
  always @(posedge Clk)
    for (int k = 0; k < 2; k++) begin
      int s;
      if (Rst) begin
        m_pc[k] = rv[k]; m_w[k] = 0; m_ra[k] = rv[k]; valid = 1;
      end else if (!En) m_w[k] = 0;
      else if (Call) begin
        m_ra[k] = (m_pc[k] + 1) % 256; m_pc[k] = Target; m_w[k] = 0;
      end else if (Ret) begin
        m_pc[k] = m_ra[k]; m_w[k] = 0;
      end else begin
        case (Op)
          2'd1: begin s = m_pc[k] + 1; m_w[k] = s > 255; m_pc[k] = s & 255; end
          2'd2: begin m_pc[k] = Target; m_w[k] = 0; end
          2'd3: begin s = m_pc[k] + $signed(Offset); m_w[k] = s < 0 || s > 255; m_pc[k] = s & 255; end
          default: m_w[k] = 0;
        endcase
      end
    end

  always @(negedge Clk)
    if (valid) begin
      chk("pc_a", pc_a, m_pc[0]);
      chk("pcinc_a", inc_a, (m_pc[0] + 1) & 255);
      chk("wrap_a", wrap_a, m_w[0]);
      chk("pc_b", pc_b, m_pc[1]);
      chk("pcinc_b", inc_b, (m_pc[1] + 1) & 255);
      chk("wrap_b", wrap_b, m_w[1]);
`ifdef PC_CALL_RET_EN
      chk("ra_a", ra_a, m_ra[0]);
      chk("ra_b", ra_b, m_ra[1]);
`endif
    end

  task automatic step(input logic r, input logic e, input logic [1:0] o,
                      input logic [7:0] t = 0, input logic [7:0] f = 0,
                      input logic c = 0, input logic rt = 0);
    Rst = r; En = e; Op = o; Target = t; Offset = f; Call = c; Ret = rt;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    step(1, 1, 2'd1);
    step(1, 1, 2'd1);
    chk("rst_pc", pc_a, 8'h00);
    chk("rst_pcinc", inc_a, 8'h01);
    chk("rst_wrap", wrap_a, 0);
    chk("rst_pc_b", pc_b, 8'h80);
    repeat (3) step(0, 1, 2'd1);
    chk("inc3", pc_a, 8'h03);
    step(0, 1, 2'd2, 8'h10);
    step(0, 0, 2'd2, 8'h55);
    step(0, 0, 2'd2, 8'h55);
    chk("stall", pc_a, 8'h10);
    step(0, 1, 2'd0, 8'h55);
    chk("hold", pc_a, 8'h10);
    step(0, 1, 2'd2, 8'hFF);
    step(0, 1, 2'd1);
    chk("incwrap_pc", pc_a, 8'h00);
    chk("incwrap_w", wrap_a, 1);
    step(0, 1, 2'd1);
    chk("inc_after_pc", pc_a, 8'h01);
    chk("inc_after_w", wrap_a, 0);
    step(0, 1, 2'd2, 8'h20);
    step(0, 1, 2'd3, 8'h00, 8'hF0);
    chk("rel_neg_pc", pc_a, 8'h10);
    chk("rel_neg_w", wrap_a, 0);
    step(0, 1, 2'd2, 8'h05);
    step(0, 1, 2'd3, 8'h00, 8'hF0);
    chk("rel_under_pc", pc_a, 8'hF5);
    chk("rel_under_w", wrap_a, 1);
    step(0, 1, 2'd2, 8'hF8);
    step(0, 1, 2'd3, 8'h00, 8'h10);
    chk("rel_over_pc", pc_a, 8'h08);
    chk("rel_over_w", wrap_a, 1);
    step(0, 1, 2'd3, 8'h00, 8'h10);
    chk("rel_pos_w", wrap_a, 0);
    step(1, 1, 2'd2, 8'hAA);
    chk("rst_mid_a", pc_a, 8'h00);
    chk("rst_mid_b", pc_b, 8'h80);
`ifdef PC_CALL_RET_EN
    step(0, 1, 2'd2, 8'h30);
    step(0, 1, 2'd1, 8'h90, 8'h00, 1, 0);
    chk("call_pc", pc_a, 8'h90);
    chk("call_ra", ra_a, 8'h31);
    step(0, 1, 2'd1);
    step(0, 1, 2'd1);
    chk("pre_ret", pc_a, 8'h92);
    step(0, 1, 2'd2, 8'h77, 8'h00, 0, 1);
    chk("ret_pc", pc_a, 8'h31);
    step(0, 1, 2'd3, 8'h40, 8'h05, 1, 1);
    chk("callret_pc", pc_a, 8'h40);
    chk("callret_ra", ra_a, 8'h32);
    step(0, 0, 2'd1, 8'h11, 8'h00, 1, 0);
    chk("call_stall", pc_a, 8'h40);
`endif
    step(0, 0, 2'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
